audio_mix_dac: RTL and testbench
================================

// Module: audio_mix_dac
// PURPOSE
//   Parametrised successor to the fixed 2-channel 12-bit sigma-delta DAC pair at the board top level.
//   Mixes NCH unsigned audio channels into a stereo pair using per-channel volume and L/R routing.
//   Channels are accumulated one per clock; the stereo sum is scaled and saturated.
//   It then drives two first-order sigma-delta bitstreams with optional LFSR dither.
//   Sits between main (audio sources) and the dsgL/dsgR board pins.
// PARAMETERS
//   NCH    4   number of input channels (1..16)
//   DW     12  channel sample width and DAC level width
//   VOLW   4   per-channel volume width; gain = vol/2^VOLW
//   DITHER 1   1 = add LFSR bit to sigma-delta input LSB, 0 = no dither
// PORTS
//   clock     in   1           system clock
//   reset     in   1           synchronous, active-high
//   stb       in   1           sample strobe: request a new mix
//   ch_data   in   NCH*DW      unsigned samples; channel i at [i*DW +: DW]
//   ch_vol    in   NCH*VOLW    volume; channel i at [i*VOLW +: VOLW]
//   ch_pan    in   NCH*2       routing; bit 2i = to left, bit 2i+1 = to right
//   mute      in   1           force both bitstreams low
//   clr       in   1           clear sticky flags sat/overrun
//   busy      out  1           mix in progress
//   sat       out  1           sticky: a mix result clipped
//   overrun   out  1           sticky: stb arrived while busy
//   level_l   out  DW          current left DAC level
//   level_r   out  DW          current right DAC level
//   q         out  2           sigma-delta bitstreams, [0]=left, [1]=right
// BEHAVIOUR
//   Reset (sync): all outputs 0; FSM=IDLE; sigma accumulators 0; LFSR = 16'hACE1.
//     A reset mid-mix aborts the mix; the levels are not updated.
//   FSM states are IDLE, MIX and LOAD:
//     IDLE: on stb, snapshot ch_data/ch_vol/ch_pan, clear both mix accumulators, set idx=0 -> MIX.
//       busy=1 from the next cycle.
//     MIX (NCH cycles): prod = data[idx]*vol[idx] (DW+VOLW bits).
//       Add prod to accL if pan[2idx], and to accR if pan[2idx+1].
//       idx++; after idx=NCH-1 -> LOAD.
//       Accumulator width is DW+VOLW+clog2(NCH), so no internal overflow.
//     LOAD (1 cycle): s = acc >> VOLW. If s > 2^DW-1, level = {DW{1}} and sat<=1; else level = s[DW-1:0].
//       Update level_l and level_r together -> IDLE; busy=0.
//   Latency: stb at cycle t -> level_l/level_r valid at t+NCH+2; busy high for cycles t+1..t+NCH+1.
//   stb while busy: ignored (the snapshot is unchanged) and overrun<=1.
//     stb in the same cycle that LOAD returns to IDLE is also ignored.
//   sat/overrun: cleared by reset or clr. If set and clr occur in the same cycle, set wins.
//   Sigma-delta, per channel, every clock:
//     sum = {1'b0, acc[DW-1:0]} + level + (DITHER ? lfsr[0] : 0); acc <= sum[DW-1:0]; q <= sum[DW].
//     Mean of q = level/2^DW, with exactly level ones per 2^DW clocks when DITHER=0.
//   LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock and is shared by L and R.
//   mute: q forced to 0 and sigma accumulators held at 0 while high. The mixer and levels keep running.
//   Level changes take effect on the following clock; the sigma accumulators are not reset on a level change.
// TESTING
//   Reset: assert reset 2 cycles -> q=0, busy=0, level_l=level_r=0, sat=overrun=0.
//   NCH=4, DW=12, VOLW=4, DITHER=0: ch0=12'h800, vol0=15, pan0=L; other vols 0; pulse stb.
//     -> busy for 5 cycles; level_l=12'h780, level_r=0.
//     -> over 4096 clocks q[0] has exactly 1920 ones and q[1] has 0.
//   All 4 channels 12'hFFF, vol 15, pan L+R; stb -> level_l=level_r=12'hFFF, sat=1.
//     -> q has 4095 ones per 4096 clocks; clr -> sat=0.
//   stb, then stb again 2 cycles later -> second stb ignored, overrun=1, levels reflect the first snapshot only.
//   stb, then reset during MIX (cycle t+2) -> busy=0, levels 0; a fresh stb then completes normally at t'+6.
//   Level 12'h400 playing, mute=1 for 100 clocks -> q=0 throughout.
//     Release mute -> q resumes from accumulator 0, giving 1024 ones per 4096 clocks.

Source files
------------

// File: rtl/audio_mix_dac.sv
// Stereo mixer for NCH unsigned channels feeding two first-order sigma-delta DACs.
// Channels are summed one per clock, scaled by 2^-VOLW and saturated to DW bits.
module audio_mix_dac #(
  parameter int NCH    = 4,
  parameter int DW     = 12,
  parameter int VOLW   = 4,
  parameter int DITHER = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stb,
  input  logic [NCH*DW-1:0]    i_ch_data,
  input  logic [NCH*VOLW-1:0]  i_ch_vol,
  input  logic [NCH*2-1:0]     i_ch_pan,
  input  logic                 i_mute,
  input  logic                 i_clr,
  output logic                 o_busy,
  output logic                 o_sat,
  output logic                 o_overrun,
  output logic [DW-1:0]        o_level_l,
  output logic [DW-1:0]        o_level_r,
  output logic [1:0]           o_q
);

  localparam int PW = DW + VOLW;
  localparam int AW = PW + $clog2(NCH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = AW - VOLW;
  localparam logic [SW-1:0] LVL_MAX = SW'({DW{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_MIX, S_LOAD} state_t;

  state_t                r_state;
  logic [NCH*DW-1:0]     r_data;
  logic [NCH*VOLW-1:0]   r_vol;
  logic [NCH*2-1:0]      r_pan;
  logic [IW-1:0]         r_idx;
  logic [AW-1:0]         r_acc_l;
  logic [AW-1:0]         r_acc_r;
  logic [15:0]           r_lfsr;

  logic [DW-1:0]         w_data [NCH];
  logic [VOLW-1:0]       w_vol  [NCH];
  logic                  w_to_l [NCH];
  logic                  w_to_r [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : gen_unpack
      assign w_data[gi] = r_data[gi*DW +: DW];
      assign w_vol[gi]  = r_vol[gi*VOLW +: VOLW];
      assign w_to_l[gi] = r_pan[2*gi];
      assign w_to_r[gi] = r_pan[2*gi+1];
    end
  endgenerate

  logic [PW-1:0] w_prod;
  logic [SW-1:0] w_s_l;
  logic [SW-1:0] w_s_r;
  logic          w_clip_l;
  logic          w_clip_r;

  assign w_prod   = PW'(w_data[r_idx]) * PW'(w_vol[r_idx]);
  assign w_s_l    = r_acc_l[AW-1:VOLW];
  assign w_s_r    = r_acc_r[AW-1:VOLW];
  assign w_clip_l = (w_s_l > LVL_MAX);
  assign w_clip_r = (w_s_r > LVL_MAX);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_vol     <= '0;
      r_pan     <= '0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      o_busy    <= 1'b0;
      o_sat     <= 1'b0;
      o_overrun <= 1'b0;
      o_level_l <= '0;
      o_level_r <= '0;
    end else begin
      // busy is high in every non-IDLE state, so it doubles as the overrun qualifier
      if (i_stb && o_busy)
        o_overrun <= 1'b1;
      else if (i_clr)
        o_overrun <= 1'b0;
      if (i_clr)
        o_sat <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_stb) begin
            r_data  <= i_ch_data;
            r_vol   <= i_ch_vol;
            r_pan   <= i_ch_pan;
            r_acc_l <= '0;
            r_acc_r <= '0;
            r_idx   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_MIX;
          end
        end
        S_MIX: begin
          if (w_to_l[r_idx])
            r_acc_l <= r_acc_l + AW'(w_prod);
          if (w_to_r[r_idx])
            r_acc_r <= r_acc_r + AW'(w_prod);
          r_idx <= r_idx + 1'b1;
          if (r_idx == IW'(NCH - 1))
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          o_level_l <= w_clip_l ? {DW{1'b1}} : w_s_l[DW-1:0];
          o_level_r <= w_clip_r ? {DW{1'b1}} : w_s_r[DW-1:0];
          if (w_clip_l || w_clip_r)
            o_sat <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_lfsr <= 16'hACE1;
    else
      r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  logic          w_dith;
  logic [DW-1:0] w_lvl [2];

  assign w_dith   = (DITHER != 0) ? r_lfsr[0] : 1'b0;
  assign w_lvl[0] = o_level_l;
  assign w_lvl[1] = o_level_r;

  generate
    for (gi = 0; gi < 2; gi++) begin : gen_sd
      logic [DW-1:0] r_acc;
      logic          r_q;
      logic [DW:0]   w_sum;

      assign w_sum   = {1'b0, r_acc} + {1'b0, w_lvl[gi]} + (DW+1)'(w_dith);
      assign o_q[gi] = r_q;

      // The carry out of the phase accumulator is the output bit
      always_ff @(posedge i_clock) begin
        if (i_reset || i_mute) begin
          r_acc <= '0;
          r_q   <= 1'b0;
        end else begin
          r_acc <= w_sum[DW-1:0];
          r_q   <= w_sum[DW];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_audio_mix_dac.sv
// Self-checking bench for audio_mix_dac: arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed levels and bitstream densities.
module tb_audio_mix_dac;
  localparam int NCH    = 4;
  localparam int DW     = 12;
  localparam int VOLW   = 4;
  localparam int DITHER = 0;
  localparam int LMAX   = (1 << DW) - 1;

  logic                clk;
  logic                reset;
  logic                stb;
  logic [NCH*DW-1:0]   ch_data;
  logic [NCH*VOLW-1:0] ch_vol;
  logic [NCH*2-1:0]    ch_pan;
  logic                mute;
  logic                clr;
  logic                busy;
  logic                sat;
  logic                overrun;
  logic [DW-1:0]       level_l;
  logic [DW-1:0]       level_r;
  logic [1:0]          q;

  int checks   = 0;
  int failures = 0;

  audio_mix_dac #(.NCH(NCH), .DW(DW), .VOLW(VOLW), .DITHER(DITHER)) dut (
    .i_clock   (clk),
    .i_reset   (reset),
    .i_stb     (stb),
    .i_ch_data (ch_data),
    .i_ch_vol  (ch_vol),
    .i_ch_pan  (ch_pan),
    .i_mute    (mute),
    .i_clr     (clr),
    .o_busy    (busy),
    .o_sat     (sat),
    .o_overrun (overrun),
    .o_level_l (level_l),
    .o_level_r (level_r),
    .o_q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_valid = 1'b0;
  bit m_busy, m_sat, m_ovr, m_clip_pend;
  int m_cnt, m_ll, m_lr, m_pend_l, m_pend_r;
  int m_sd_acc [2];
  bit m_q [2];
  int m_lfsr;

  // Scaled, unclipped mix for one side (0 = left, 1 = right) from the live inputs
  function automatic int mix_sum(input int side);
    int s = 0;
    for (int i = 0; i < NCH; i++)
      if (ch_pan[2*i+side])
        s += int'(ch_data[i*DW +: DW]) * int'(ch_vol[i*VOLW +: VOLW]);
    return s >> VOLW;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_busy = 0; m_sat = 0; m_ovr = 0; m_cnt = 0;
      m_ll = 0; m_lr = 0;
      m_sd_acc[0] = 0; m_sd_acc[1] = 0; m_q[0] = 0; m_q[1] = 0;
      m_lfsr = 'hACE1;
    end else if (m_valid) begin
      bit n_sat, n_ovr;
      int s, fb;
      for (int c = 0; c < 2; c++) begin
        if (mute) begin
          m_sd_acc[c] = 0; m_q[c] = 0;
        end else begin
          s = m_sd_acc[c] + (c == 0 ? m_ll : m_lr) + ((DITHER != 0) ? (m_lfsr & 1) : 0);
          m_q[c] = (s > LMAX);
          m_sd_acc[c] = s & LMAX;
        end
      end
      fb = ((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (fb << 15);

      n_ovr = m_ovr;
      if (stb && m_busy) n_ovr = 1;
      else if (clr) n_ovr = 0;
      n_sat = clr ? 1'b0 : m_sat;

      if (!m_busy) begin
        if (stb) begin
          m_pend_l = mix_sum(0);
          m_pend_r = mix_sum(1);
          m_clip_pend = (m_pend_l > LMAX) || (m_pend_r > LMAX);
          if (m_pend_l > LMAX) m_pend_l = LMAX;
          if (m_pend_r > LMAX) m_pend_r = LMAX;
          m_cnt = NCH + 1;
          m_busy = 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ll = m_pend_l;
          m_lr = m_pend_r;
          if (m_clip_pend) n_sat = 1;
          m_busy = 0;
        end
      end
      m_sat = n_sat;
      m_ovr = n_ovr;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_busy",    int'(busy),    int'(m_busy));
      chk("cyc_sat",     int'(sat),     int'(m_sat));
      chk("cyc_overrun", int'(overrun), int'(m_ovr));
      chk("cyc_level_l", int'(level_l), m_ll);
      chk("cyc_level_r", int'(level_r), m_lr);
      chk("cyc_q0",      int'(q[0]),    int'(m_q[0]));
      chk("cyc_q1",      int'(q[1]),    int'(m_q[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int d, input int v, input int p);
    ch_data[i*DW +: DW]     = DW'(d);
    ch_vol[i*VOLW +: VOLW]  = VOLW'(v);
    ch_pan[2*i +: 2]        = 2'(p);
  endtask

  task automatic pulse_stb();
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    if (busy) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic count_ones(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (n) begin
      tick();
      c0 += int'(q[0]);
      c1 += int'(q[1]);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int n, c0, c1;
    reset = 1'b1; stb = 1'b0; mute = 1'b0; clr = 1'b0;
    ch_data = '0; ch_vol = '0; ch_pan = '0;
    tick(); tick();
    chk("rst_q",       int'(q),       0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_level_l", int'(level_l), 0);
    chk("rst_level_r", int'(level_r), 0);
    chk("rst_sat",     int'(sat),     0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    tick();

    // single channel to left; muted-volume channels must not contribute
    set_ch(0, 'h800, 15, 1);
    set_ch(1, 'h123, 0, 3);
    set_ch(2, 'hFFF, 0, 3);
    set_ch(3, 'h000, 0, 0);
    pulse_stb();
    wait_idle("t1", n);
    chk("t1_busy_cycles", n, 5);
    chk("t1_level_l", int'(level_l), 'h780);
    chk("t1_level_r", int'(level_r), 0);
    tick(); tick();
    count_ones(4096, c0, c1);
    chk("t1_ones_l", c0, 1920);
    chk("t1_ones_r", c1, 0);

    // full-scale on every channel, both sides: saturates
    for (int i = 0; i < NCH; i++) set_ch(i, 'hFFF, 15, 3);
    pulse_stb();
    wait_idle("t2", n);
    chk("t2_level_l", int'(level_l), 'hFFF);
    chk("t2_level_r", int'(level_r), 'hFFF);
    chk("t2_sat",     int'(sat),     1);
    tick(); tick();
    count_ones(4096, c0, c1);
    chk("t2_ones_l", c0, 4095);
    chk("t2_ones_r", c1, 4095);
    pulse_clr();
    chk("t2_sat_clr", int'(sat), 0);

    // second stb during MIX is ignored and flags overrun
    set_ch(0, 'h400, 8, 1);
    set_ch(1, 'h200, 15, 2);
    set_ch(2, 'hFFF, 0, 3);
    set_ch(3, 'hFFF, 0, 3);
    pulse_stb();
    tick();
    set_ch(0, 'hFFF, 15, 3);
    pulse_stb();
    chk("t3_overrun", int'(overrun), 1);
    wait_idle("t3", n);
    chk("t3_level_l", int'(level_l), 'h200);
    chk("t3_level_r", int'(level_r), 'h1E0);
    chk("t3_sat",     int'(sat),     0);
    pulse_clr();
    chk("t3_ovr_clr", int'(overrun), 0);

    // stb landing in the LOAD cycle is ignored; this mix clips on the right only
    pulse_stb();
    repeat (4) tick();
    pulse_stb();
    chk("t3b_busy",    int'(busy),    0);
    chk("t3b_overrun", int'(overrun), 1);
    chk("t3b_level_l", int'(level_l), 'hEFF);
    chk("t3b_level_r", int'(level_r), 'hFFF);
    chk("t3b_sat",     int'(sat),     1);
    pulse_clr();

    // reset in the middle of a mix aborts it
    set_ch(0, 'h800, 8, 3);
    set_ch(1, 'h000, 0, 0);
    for (int i = 2; i < NCH; i++) set_ch(i, 'h000, 0, 0);
    pulse_stb();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy",    int'(busy),    0);
    chk("t4_level_l", int'(level_l), 0);
    chk("t4_level_r", int'(level_r), 0);
    pulse_stb();
    repeat (4) tick();
    chk("t4_busy_t5",  int'(busy),    1);
    chk("t4_lvl_t5",   int'(level_l), 0);
    tick();
    chk("t4_busy_t6",  int'(busy),    0);
    chk("t4_level_l2", int'(level_l), 'h400);
    chk("t4_level_r2", int'(level_r), 'h400);

    // mute silences the bitstreams; release restarts from a zero accumulator
    tick(); tick();
    mute = 1'b1;
    count_ones(100, c0, c1);
    chk("t5_mute_l", c0, 0);
    chk("t5_mute_r", c1, 0);
    mute = 1'b0;
    count_ones(4096, c0, c1);
    chk("t5_ones_l", c0, 1024);
    chk("t5_ones_r", c1, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
